// File: rtl/adder_8bit_serial_if.sv
// ---------------------------------------------------------------------------
// adder_8bit_serial_if
// Request/result bundle for the bit-serial adder.
//   Start     : request a new addition (sampled only while the adder is idle)
//   A, B      : operands, captured when Start is accepted
//   Carry_in  : carry into bit 0, captured when Start is accepted
//   SUM       : registered result, low WIDTH bits of A + B + Carry_in
//   Carry_out : registered carry out of the top bit
//   Busy      : high while bits are being shifted through the adder
//   Done      : one-cycle pulse marking SUM/Carry_out as newly valid
// master = requester side, slave = adder side.
// ---------------------------------------------------------------------------
interface adder_8bit_serial_if #(
   parameter int WIDTH = 8
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Carry_in;
   logic [WIDTH-1:0] SUM;
   logic             Carry_out;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, A, B, Carry_in,
      input  SUM, Carry_out, Busy, Done
   );

   modport slave (
      input  Start, A, B, Carry_in,
      output SUM, Carry_out, Busy, Done
   );
endinterface

// File: rtl/adder_8bit_serial.sv
// ---------------------------------------------------------------------------
// adder_8bit_serial
// Bit-serial adder: one full adder processes one bit pair per clock, LSB
// first. A request accepted in IDLE spends WIDTH cycles in SHIFT, then one
// cycle in DONE, then returns to IDLE (WIDTH+2 cycles per operation).
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset (wins over everything)
//   bus   : adder_8bit_serial_if.slave (Start/A/B/Carry_in in,
//           SUM/Carry_out/Busy/Done out, all outputs registered)
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module adder_8bit_serial #(
   parameter int WIDTH = 8
) (
   input  logic               Clock,
   input  logic               Reset,
   adder_8bit_serial_if.slave bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // One-bit full adder: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   state_t             state_r;
   state_t             state_nx_s;
   logic               busy_r;
   logic               busy_nx_s;
   logic               done_r;
   logic               done_nx_s;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               carry_r;
   logic [WIDTH-1:0]   res_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   sum_r;
   logic               cout_r;
   logic [1:0]         fa_s;
   logic [WIDTH-1:0]   res_nx_s;
   logic               last_s;

   // Serial datapath: current bit pair through the full adder, and the
   // result register with the new sum bit entering at the top so that after
   // WIDTH shifts bit 0 has reached position 0.
   always_comb begin
      fa_s     = full_add(a_r[0], b_r[0], carry_r);
      res_nx_s = {fa_s[0], res_r[WIDTH-1:1]};
      last_s   = (cnt_r == CNT_W'(WIDTH - 1));
   end

   // FSM state register plus registered Busy/Done.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   // FSM next-state logic; Start is looked at only in IDLE.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.Start) begin
               state_nx_s = ST_SHIFT;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (last_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_SHIFT;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from the next state so Busy/Done come from flops.
   always_comb begin
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_nx_s)
         ST_SHIFT: busy_nx_s = 1'b1;
         ST_DONE:  done_nx_s = 1'b1;
         default: begin
            busy_nx_s = 1'b0;
            done_nx_s = 1'b0;
         end
      endcase
   end

   // Operand capture, bit-serial shifting and result publication.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         res_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.Start) begin
                  a_r     <= bus.A;
                  b_r     <= bus.B;
                  carry_r <= bus.Carry_in;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            ST_SHIFT: begin
               a_r     <= a_r >> 1;
               b_r     <= b_r >> 1;
               carry_r <= fa_s[1];
               res_r   <= res_nx_s;
               cnt_r   <= cnt_r + CNT_W'(1);
               // SUM/Carry_out move only here, on the final bit.
               if (last_s) begin
                  sum_r  <= res_nx_s;
                  cout_r <= fa_s[1];
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.SUM       = sum_r;
   assign bus.Carry_out = cout_r;
   assign bus.Busy      = busy_r;
   assign bus.Done      = done_r;

endmodule

// File: tb/tb_adder_8bit_serial.sv
// ---------------------------------------------------------------------------
// tb_adder_8bit_serial
// Directed-vector bench for adder_8bit_serial (WIDTH = 8). Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_adder_8bit_serial;
   localparam int WIDTH = 8;

   logic Clock = 1'b0;
   logic Reset;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   adder_8bit_serial_if #(.WIDTH(WIDTH)) bus ();

   adder_8bit_serial #(.WIDTH(WIDTH)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // One full operation from IDLE. The accepting edge counts as edge 1, so
   // Done must first be seen after edge 9.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input string tag);
      logic [7:0] prev_sum;
      int         lat;
      bit         held;
      prev_sum = bus.SUM;
      held     = 1'b1;
      bus.A = a; bus.B = b; bus.Carry_in = cin; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      // Operand changes after acceptance must not matter.
      bus.A = ~a; bus.B = ~b; bus.Carry_in = ~cin;
      check_eq({tag, "_busy"}, 32'(bus.Busy), 32'd1);
      lat = 1;
      while (!bus.Done && lat < 20) begin
         if (bus.SUM !== prev_sum) held = 1'b0;
         step();
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'd9);
      check_eq({tag, "_sum"}, 32'(bus.SUM), 32'(es));
      check_eq({tag, "_cout"}, 32'(bus.Carry_out), 32'(ec));
      check_eq({tag, "_busy_at_done"}, 32'(bus.Busy), 32'd0);
      check_eq({tag, "_sum_held"}, 32'(held), 32'd1);
      step();
      check_eq({tag, "_done_width"}, 32'(bus.Done), 32'd0);
   endtask

   initial begin : main
      int dones;
      int busy_after;
      int overlap;
      int t_done[3];
      logic [7:0] sum_seen;

      bus.Start = 1'b0; bus.A = 8'd0; bus.B = 8'd0; bus.Carry_in = 1'b0;
      Reset = 1'b1;
      step();
      bus.Start = 1'b1;          // Reset must beat Start
      step();
      check_eq("rst_sum",  32'(bus.SUM), 32'd0);
      check_eq("rst_cout", 32'(bus.Carry_out), 32'd0);
      check_eq("rst_busy", 32'(bus.Busy), 32'd0);
      check_eq("rst_done", 32'(bus.Done), 32'd0);
      bus.Start = 1'b0;
      Reset = 1'b0;
      step();
      check_eq("idle_busy", 32'(bus.Busy), 32'd0);

      run_op(8'd5,   8'd5,  1'b0, 8'd10, 1'b0, "add5_5");
      run_op(8'd251, 8'd10, 1'b0, 8'd5,  1'b1, "wrap251_10");
      run_op(8'd7,   8'd7,  1'b1, 8'd15, 1'b0, "add7_7_c");
      run_op(8'd254, 8'd1,  1'b1, 8'd0,  1'b1, "wrap254_1_c");

      // Start re-pulsed during SHIFT is dropped.
      bus.A = 8'd3; bus.B = 8'd4; bus.Carry_in = 1'b0; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      step(); step();
      bus.A = 8'd100; bus.B = 8'd100; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      dones = 0; busy_after = 0; sum_seen = 8'd0;
      for (int i = 0; i < 30; i++) begin
         if (bus.Done) begin
            dones++;
            sum_seen = bus.SUM;
         end else if (dones > 0 && bus.Busy) begin
            busy_after++;
         end
         step();
      end
      check_eq("drop_dones", 32'(dones), 32'd1);
      check_eq("drop_sum", 32'(sum_seen), 32'd7);
      check_eq("drop_no_second_op", 32'(busy_after), 32'd0);

      // Reset on SHIFT edge 5 aborts without Done.
      bus.A = 8'd255; bus.B = 8'd255; bus.Carry_in = 1'b1; bus.Start = 1'b1;
      step();
      bus.Start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check_eq("abort_sum",  32'(bus.SUM), 32'd0);
      check_eq("abort_cout", 32'(bus.Carry_out), 32'd0);
      check_eq("abort_busy", 32'(bus.Busy), 32'd0);
      check_eq("abort_done", 32'(bus.Done), 32'd0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.Done) dones++;
         step();
      end
      check_eq("abort_no_done", 32'(dones), 32'd0);
      run_op(8'd1, 8'd2, 1'b0, 8'd3, 1'b0, "after_abort");

      // Start held high: back-to-back operations every 10 cycles.
      bus.A = 8'd1; bus.B = 8'd1; bus.Carry_in = 1'b0; bus.Start = 1'b1;
      dones = 0; overlap = 0;
      for (int i = 0; i < 60 && dones < 3; i++) begin
         step();
         if (bus.Busy && bus.Done) overlap++;
         if (bus.Done) begin
            t_done[dones] = cyc;
            check_eq("b2b_sum", 32'(bus.SUM), 32'd2);
            dones++;
         end
      end
      bus.Start = 1'b0;
      check_eq("b2b_dones", 32'(dones), 32'd3);
      if (dones == 3) begin
         check_eq("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'd10);
         check_eq("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'd10);
      end
      check_eq("b2b_busy_done_overlap", 32'(overlap), 32'd0);

      step(); step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
